// File: rtl/instr_mem_loader.sv
// Writable instruction memory fed by a byte-stream load engine; holds fetch in reset until an image is complete.
// Writes land one byte per accepted handshake. Reads are combinational. in_ready is high only while loading.
module instr_mem_loader #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [7:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              loaded,
  output logic              fetch_hold,
  output logic [DATA_W-1:0] checksum
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                loaded_q, loaded_d;
  logic                wr_en;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                rd_in_range;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    checksum_d = checksum_q;
    loaded_d   = loaded_q;
    wr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          checksum_d = '0;
          loaded_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // Abort wins over a same-cycle transfer so a half-written byte never lands.
        if (load_abort) begin
          state_d  = S_IDLE;
          loaded_d = 1'b0;
        end else if (in_valid) begin
          wr_en      = 1'b1;
          checksum_d = checksum_q ^ in_data;
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d = '0;
            state_d  = S_DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        loaded_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      checksum_q <= '0;
      loaded_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      checksum_q <= checksum_d;
      loaded_q   <= loaded_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end
  end

  // The fetch pointer is 8 bits regardless of DEPTH; anything past the array reads as zero.
  assign rd_in_range = ({1'b0, rd_addr} < 9'(DEPTH));
  assign rd_data     = rd_in_range ? mem_q[rd_addr[AW-1:0]] : '0;

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign loaded     = loaded_q;
  assign fetch_hold = ~loaded_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_instr_mem_loader;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;

  localparam int SEL_RD     = 0;
  localparam int SEL_HOLD   = 1;
  localparam int SEL_LOADED = 2;
  localparam int SEL_READY  = 3;
  localparam int SEL_BUSY   = 4;
  localparam int SEL_CSUM   = 5;
  localparam int SEL_DONE   = 6;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] val;
  } chk_t;

  logic              clk;
  logic              reset;
  logic              load_start;
  logic              load_abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [7:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              loaded;
  logic              fetch_hold;
  logic [DATA_W-1:0] checksum;

  chk_t       chk_q[$];
  logic [7:0] done_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       end_req = 1'b0;

  instr_mem_loader #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_abort (load_abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .loaded     (loaded),
    .fetch_hold (fetch_hold),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [7:0] actual(int sel);
    case (sel)
      SEL_RD:     actual = rd_data;
      SEL_HOLD:   actual = {7'd0, fetch_hold};
      SEL_LOADED: actual = {7'd0, loaded};
      SEL_READY:  actual = {7'd0, in_ready};
      SEL_BUSY:   actual = {7'd0, busy};
      SEL_CSUM:   actual = checksum;
      SEL_DONE:   actual = {7'd0, done};
      default:    actual = 8'hxx;
    endcase
  endfunction

  // Single monitor process owns the counters.
  always @(negedge clk) begin
    chk_t       c;
    logic [7:0] a;
    logic [7:0] e;
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: actual done=1 required no done pulse");
      end else begin
        e = done_q.pop_front();
        if (checksum !== e) begin
          errors++;
          $display("FAIL done_checksum: actual %02h required %02h", checksum, e);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      a = actual(c.sel);
      checks++;
      if (a !== c.val) begin
        errors++;
        $display("FAIL %s: actual %02h required %02h", c.name, a, c.val);
      end
    end
    if (end_req) begin
      checks++;
      if (done_q.size() != 0) begin
        errors++;
        $display("FAIL done_missing: actual %0d pending pulses required 0", done_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input string name, input int sel, input logic [7:0] val);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.val  = val;
    chk_q.push_back(c);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      push_chk("busy_in_gap", SEL_BUSY, 8'h01);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    push_chk("in_ready_load", SEL_READY, 8'h01);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_mem(input string name, input logic [7:0] m0, input logic [7:0] m1,
                           input logic [7:0] m2, input logic [7:0] m3);
    logic [7:0] exp_w [4];
    exp_w[0] = m0; exp_w[1] = m1; exp_w[2] = m2; exp_w[3] = m3;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 8'(i);
      push_chk(name, SEL_RD, exp_w[i]);
      tick();
    end
  endtask

  task automatic check_idle_loaded(input logic [7:0] csum);
    push_chk("loaded_after_done", SEL_LOADED, 8'h01);
    push_chk("fetch_hold_after_done", SEL_HOLD, 8'h00);
    push_chk("in_ready_idle", SEL_READY, 8'h00);
    push_chk("busy_idle", SEL_BUSY, 8'h00);
    push_chk("checksum_final", SEL_CSUM, csum);
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    rd_addr    = '0;

    // Reset then idle
    tick();
    tick();
    reset = 1'b1;
    push_chk("rst_fetch_hold", SEL_HOLD, 8'h01);
    push_chk("rst_loaded", SEL_LOADED, 8'h00);
    push_chk("rst_in_ready", SEL_READY, 8'h00);
    push_chk("rst_busy", SEL_BUSY, 8'h00);
    push_chk("rst_done", SEL_DONE, 8'h00);
    push_chk("rst_checksum", SEL_CSUM, 8'h00);
    check_mem("rst_mem", 8'h00, 8'h00, 8'h00, 8'h00);

    // Full load, no gaps; E4^22^14^DA = 08
    start_load();
    push_chk("load_busy", SEL_BUSY, 8'h01);
    push_chk("load_loaded_low", SEL_LOADED, 8'h00);
    done_q.push_back(8'h08);
    send_byte(8'hE4, 0);
    send_byte(8'h22, 0);
    send_byte(8'h14, 0);
    send_byte(8'hDA, 0);
    push_chk("done_pulse", SEL_DONE, 8'h01);
    push_chk("done_in_ready", SEL_READY, 8'h00);
    push_chk("done_hold_still", SEL_HOLD, 8'h01);
    tick();
    check_idle_loaded(8'h08);
    push_chk("done_cleared", SEL_DONE, 8'h00);
    check_mem("full_mem", 8'hE4, 8'h22, 8'h14, 8'hDA);

    // Same image with 3-cycle gaps between bytes
    start_load();
    push_chk("gap_loaded_low", SEL_LOADED, 8'h00);
    push_chk("gap_hold_high", SEL_HOLD, 8'h01);
    done_q.push_back(8'h08);
    send_byte(8'hE4, 0);
    send_byte(8'h22, 3);
    send_byte(8'h14, 3);
    send_byte(8'hDA, 3);
    tick();
    check_idle_loaded(8'h08);
    check_mem("gap_mem", 8'hE4, 8'h22, 8'h14, 8'hDA);

    // Abort together with a valid byte: C3 must not land
    start_load();
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    in_valid   = 1'b1;
    in_data    = 8'hC3;
    load_abort = 1'b1;
    tick();
    in_valid   = 1'b0;
    load_abort = 1'b0;
    push_chk("abort_busy", SEL_BUSY, 8'h00);
    push_chk("abort_in_ready", SEL_READY, 8'h00);
    push_chk("abort_loaded", SEL_LOADED, 8'h00);
    push_chk("abort_hold", SEL_HOLD, 8'h01);
    push_chk("abort_checksum", SEL_CSUM, 8'h13);
    check_mem("abort_mem", 8'hA1, 8'hB2, 8'h14, 8'hDA);

    // Reset mid-load wipes memory and checksum
    start_load();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    push_chk("midrst_busy", SEL_BUSY, 8'h00);
    push_chk("midrst_checksum", SEL_CSUM, 8'h00);
    push_chk("midrst_hold", SEL_HOLD, 8'h01);
    check_mem("midrst_mem", 8'h00, 8'h00, 8'h00, 8'h00);
    start_load();
    done_q.push_back(8'h08);
    send_byte(8'hE4, 0);
    send_byte(8'h22, 1);
    send_byte(8'h14, 0);
    send_byte(8'hDA, 0);
    tick();
    check_idle_loaded(8'h08);
    check_mem("midrst_reload_mem", 8'hE4, 8'h22, 8'h14, 8'hDA);

    // Out-of-range reads
    rd_addr = 8'd4;
    push_chk("oor_addr4", SEL_RD, 8'h00);
    tick();
    rd_addr = 8'hFF;
    push_chk("oor_addrFF", SEL_RD, 8'h00);
    tick();

    // Reload with a stray load_start; 5A^A5^3C^C3 = 00
    start_load();
    push_chk("reload_loaded_low", SEL_LOADED, 8'h00);
    push_chk("reload_hold_high", SEL_HOLD, 8'h01);
    done_q.push_back(8'h00);
    rd_addr = 8'd0;
    push_chk("rd_old_during_write", SEL_RD, 8'hE4);
    send_byte(8'h5A, 0);
    load_start = 1'b1;
    send_byte(8'hA5, 0);
    load_start = 1'b0;
    push_chk("start_ignored_busy", SEL_BUSY, 8'h01);
    send_byte(8'h3C, 0);
    send_byte(8'hC3, 0);
    push_chk("reload_done_hold", SEL_HOLD, 8'h01);
    tick();
    check_idle_loaded(8'h00);
    check_mem("reload_mem", 8'h5A, 8'hA5, 8'h3C, 8'hC3);

    tick();
    end_req = 1'b1;
  end

endmodule
